// File: rtl/multi_queue_issue_arbiter_if.sv
// ---------------------------------------------------------------------------
// multi_queue_issue_arbiter_if
// Bundles the upstream request/valid/ack vectors and the downstream issue
// port of the multi-queue issue arbiter.
//   request_packed_in       : NUM_REQUESTER requests, requester i at [i*W +: W]
//   request_valid_packed_in : per-requester valid
//   issue_ack_packed_out    : per-requester one-cycle ack pulse (registered)
//   request_out             : granted request (registered)
//   request_valid_out       : request_out is valid
//   request_id_out          : requester index that supplied request_out
//   issue_ack_in            : downstream accepted request_out this cycle
// Modports: master = arbiter side, slave = queues + downstream stage side.
// ---------------------------------------------------------------------------
interface multi_queue_issue_arbiter_if #(
   parameter int NUM_REQUESTER              = 4,
   parameter int REQUESTER_ID_WIDTH         = 2,
   parameter int SINGLE_ENTRY_WIDTH_IN_BITS = 64
);
   logic [NUM_REQUESTER*SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_packed_in;
   logic [NUM_REQUESTER-1:0]                            request_valid_packed_in;
   logic [NUM_REQUESTER-1:0]                            issue_ack_packed_out;
   logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]               request_out;
   logic                                                request_valid_out;
   logic [REQUESTER_ID_WIDTH-1:0]                       request_id_out;
   logic                                                issue_ack_in;

   modport master (
      input  request_packed_in,
      input  request_valid_packed_in,
      input  issue_ack_in,
      output issue_ack_packed_out,
      output request_out,
      output request_valid_out,
      output request_id_out
   );

   modport slave (
      output request_packed_in,
      output request_valid_packed_in,
      output issue_ack_in,
      input  issue_ack_packed_out,
      input  request_out,
      input  request_valid_out,
      input  request_id_out
   );
endinterface

// File: rtl/multi_queue_issue_arbiter.sv
// ---------------------------------------------------------------------------
// multi_queue_issue_arbiter
// Round-robin merge of NUM_REQUESTER queue outputs onto one registered issue
// port. A grant registers the request, its requester ID and a one-cycle ack
// pulse back to the winning queue; the request is held until the downstream
// stage acknowledges it, at which point the next grant can be taken in the
// same cycle (back-to-back issue across different requesters).
// Ports:
//   clk_in   : clock
//   reset_in : asynchronous, active-high reset
//   bus      : multi_queue_issue_arbiter_if.master (see interface header)
// ---------------------------------------------------------------------------
module multi_queue_issue_arbiter #(
   parameter int NUM_REQUESTER              = 4,
   parameter int REQUESTER_ID_WIDTH         = 2,
   parameter int SINGLE_ENTRY_WIDTH_IN_BITS = 64
) (
   input logic                          clk_in,
   input logic                          reset_in,
   multi_queue_issue_arbiter_if.master  bus
);

   localparam int N   = NUM_REQUESTER;
   localparam int IDW = REQUESTER_ID_WIDTH;
   localparam int W   = SINGLE_ENTRY_WIDTH_IN_BITS;

   typedef enum logic {IDLE, HOLD} state_t;

   state_t         state, state_next;
   logic [IDW-1:0] last_grant, last_grant_next;
   logic [W-1:0]   request_next;
   logic [IDW-1:0] request_id_next;
   logic           request_valid_next;
   logic [N-1:0]   issue_ack_next;
   logic [N-1:0]   eligible;
   logic [IDW-1:0] grant_id;

   function automatic logic [N-1:0] onehot(input logic [IDW-1:0] idx);
      logic [N-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   // Search last+1, last+2, ... with an explicit wrap at N-1 so that a
   // non-power-of-2 requester count never produces an ID >= N.
   function automatic logic [IDW-1:0] rr_select(input logic [N-1:0]   elig,
                                                input logic [IDW-1:0] last);
      logic [IDW-1:0] idx;
      logic [IDW-1:0] sel;
      logic           found;
      idx   = last;
      sel   = '0;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
         idx = (idx == IDW'(N - 1)) ? '0 : idx + IDW'(1);
         if (!found && elig[idx]) begin
            sel   = idx;
            found = 1'b1;
         end
      end
      return sel;
   endfunction

   always_comb begin
      state_next         = state;
      last_grant_next    = last_grant;
      request_next       = bus.request_out;
      request_id_next    = bus.request_id_out;
      request_valid_next = bus.request_valid_out;
      issue_ack_next     = '0;   // acks are single-cycle pulses
      eligible           = '0;

      case (state)
         IDLE: eligible = bus.request_valid_packed_in;
         // The just-acked queue may still show valid for one cycle after its
         // ack pulse, so it is masked out of the back-to-back search.
         HOLD: if (bus.issue_ack_in)
                  eligible = bus.request_valid_packed_in & ~onehot(last_grant);
         default: eligible = '0;
      endcase

      grant_id = rr_select(eligible, last_grant);

      if (|eligible) begin
         request_next       = bus.request_packed_in[grant_id*W +: W];
         request_id_next    = grant_id;
         request_valid_next = 1'b1;
         issue_ack_next     = onehot(grant_id);
         last_grant_next    = grant_id;
         state_next         = HOLD;
      end else if (state == HOLD && bus.issue_ack_in) begin
         request_next       = '0;
         request_valid_next = 1'b0;
         state_next         = IDLE;
      end
   end

   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         state                    <= IDLE;
         last_grant               <= IDW'(N - 1);   // requester 0 wins first
         bus.request_out          <= '0;
         bus.request_id_out       <= '0;
         bus.request_valid_out    <= 1'b0;
         bus.issue_ack_packed_out <= '0;
      end else begin
         state                    <= state_next;
         last_grant               <= last_grant_next;
         bus.request_out          <= request_next;
         bus.request_id_out       <= request_id_next;
         bus.request_valid_out    <= request_valid_next;
         bus.issue_ack_packed_out <= issue_ack_next;
      end
   end

endmodule

// File: doc/multi_queue_issue_arbiter.md
Name: multi_queue_issue_arbiter

Overview:
- Round-robin arbiter that merges the outputs of NUM_REQUESTER fifo_queue instances into one downstream issue port.
- Sits downstream of the queues.
  - Consumes each queue's request/valid.
  - Returns a one-cycle issue ack pulse to each queue.
  - Presents one registered request plus requester ID to the next stage, holding it until acknowledged.

Parameters:
- NUM_REQUESTER, 4, number of upstream queues (≥2).
- REQUESTER_ID_WIDTH, 2, width of requester index; equals $clog2(NUM_REQUESTER).
- SINGLE_ENTRY_WIDTH_IN_BITS, 64, width of one request.

Ports:
- clk_in  input  1  clock
- reset_in  input  1  reset
- request_packed_in  input  NUM_REQUESTER*SINGLE_ENTRY_WIDTH_IN_BITS  requester i occupies bits [i*W +: W]
- request_valid_packed_in  input  NUM_REQUESTER  per-requester valid
- issue_ack_packed_out  output  NUM_REQUESTER  per-requester ack pulse, registered
- request_out  output  SINGLE_ENTRY_WIDTH_IN_BITS  granted request, registered
- request_valid_out  output  1  request_out is valid
- request_id_out  output  REQUESTER_ID_WIDTH  index of the requester that supplied request_out
- issue_ack_in  input  1  downstream accepted request_out this cycle

Behaviour:
- Reset: reset_in is asynchronous, active-high; clk_in is the clock.
- Values on reset:
  - issue_ack_packed_out=0, request_out=0, request_valid_out=0, request_id_out=0.
  - state=IDLE.
  - last_grant=NUM_REQUESTER-1, so requester 0 has first priority.
- State IDLE:
  - eligible = request_valid_packed_in.
  - If eligible != 0, select g by round-robin: the first set bit searching last_grant+1, last_grant+2, … wrapping modulo NUM_REQUESTER.
  - Next edge on a grant:
    - request_out <= request g; request_id_out <= g; request_valid_out <= 1.
    - issue_ack_packed_out <= onehot(g); last_grant <= g; state <= HOLD.
  - If eligible == 0: outputs stay 0/invalid, ack bits 0.
- State HOLD:
  - issue_ack_packed_out returns to 0 on the first HOLD cycle, so every ack is exactly one cycle wide.
  - request_out, request_id_out and request_valid_out are held stable until issue_ack_in=1.
- HOLD with issue_ack_in=1:
  - eligible = request_valid_packed_in & ~onehot(last_grant). The just-acked queue is masked because its valid may still be high for one cycle after the ack.
  - If eligible != 0: back-to-back grant by the same round-robin rule, same register updates, stay HOLD. Throughput is 1 request/cycle across ≥2 active requesters.
  - Else: request_valid_out <= 0, request_out <= 0, state <= IDLE.
- HOLD with issue_ack_in=0: no change; new valids are ignored.
- issue_ack_in while request_valid_out=0: ignored.
- Requester contract: after seeing its ack, a requester deasserts valid (or advances to its next entry) no later than one cycle later. fifo_queue meets this contract.
- Single active requester: at most one grant every 2 cycles. Two acks to the same requester never fall in consecutive cycles.
- Grant latency: requester valid sampled at edge N → request_valid_out high and ack pulse high from edge N through N+1.
- Wrap-around: a search from last_grant=NUM_REQUESTER-1 starts at index 0. The ID arithmetic is REQUESTER_ID_WIDTH bits modulo NUM_REQUESTER; a non-power-of-2 NUM_REQUESTER must never yield an ID ≥ NUM_REQUESTER.
- Reset mid-HOLD: the in-flight request is dropped, all outputs clear immediately (asynchronously), and priority returns to requester 0.
- At most one bit of issue_ack_packed_out is ever set.

Test Plan:
- Reset, then valid=4'b0001 with data0=0xA0, issue_ack_in tied 1 → edge 1: request_out=0xA0, id=0, ack=4'b0001 for one cycle. No second ack to 0 on the next cycle.
- valid=4'b1111 held, issue_ack_in=1 constant, distinct data per requester → ids issued 0,1,2,3,0,… on consecutive cycles. Each ack bit is a one-cycle pulse.
- valid=4'b0110, issue_ack_in=0 for 5 cycles, then 1 → id=1 held stable for 5 cycles with only one ack pulse. The next grant after the ack is id=2.
- last_grant=3 (grant 3 alone first), then valid=4'b1001 → wrap-around gives id=0, then id=3.
- Four fifo_queue instances (depth 4) loaded with 3 entries each, downstream ack randomly toggled → all 12 entries delivered exactly once, per-queue FIFO order kept, no ack while HOLD stalled.
- Assert reset_in mid-HOLD with request_valid_out=1 → all outputs 0 before the next edge. After release with valid=4'b1000, the first grant is id=3 from priority-0 search order.
